// File: rtl/rx_ltssm_substate_controller.sv
// RX-side LTSSM substate sequencer: loads per-substate OS count and timer values,
// arms the active lanes' OS checkers and reports completion with the next substate.
module rx_ltssm_substate_controller #(
  parameter int unsigned MAXLANES = 16,
  parameter int unsigned TIMERW   = 6,
  parameter int unsigned MAXRETRY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          substate,
  input  logic [4:0]          numberOfDetectedLanes,
  input  logic [MAXLANES-1:0] countersComparators,
  input  logic                forceDetect,
  input  logic                rxElectricalIdle,
  input  logic                timeOut,
  output logic                finish,
  output logic [3:0]          exitTo,
  output logic [MAXLANES-1:0] resetOsCheckers,
  output logic                disableDescrambler,
  output logic [TIMERW-1:0]   setTimer,
  output logic                enableTimer,
  output logic                resetTimer,
  output logic [4:0]          comparatorsCount,
  output logic [1:0]          retryCount
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_e;

  localparam logic [3:0] SUB_DETECT_QUIET  = 4'd0;
  localparam logic [3:0] SUB_DETECT_ACTIVE = 4'd1;
  localparam logic [3:0] SUB_CFG_LINKWIDTH = 4'd8;
  localparam logic [3:0] SUB_CFG_IDLE      = 4'd9;
  localparam logic [3:0] SUB_FIRST_INVALID = 4'd10;
  localparam logic [3:0] LAST_STATE_RST    = 4'hF;

  state_e              state_q, state_d;
  logic [3:0]          last_q, last_d;
  logic [3:0]          latched_q, latched_d;
  logic                forced_q, forced_d;
  logic                finish_q, finish_d;
  logic [3:0]          exit_q, exit_d;
  logic [MAXLANES-1:0] os_q, os_d;
  logic                dis_q, dis_d;
  logic [TIMERW-1:0]   tmr_q, tmr_d;
  logic                en_q, en_d;
  logic                rt_q, rt_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [1:0]          retry_q, retry_d;

  logic [MAXLANES-1:0] lane_mask_c;
  logic                abort_c;
  logic                success_c;
  logic                retry_ok_c;
  logic [3:0]          done_exit_c;

  function automatic logic [4:0] os_count(input logic [3:0] s);
    case (s)
      4'd2, 4'd3, 4'd8, 4'd9: return 5'd8;
      4'd4, 4'd5, 4'd6, 4'd7: return 5'd2;
      default:                return 5'd0;
    endcase
  endfunction

  function automatic logic [TIMERW-1:0] timer_load(input logic [3:0] s);
    case (s)
      4'd0:                         return TIMERW'(32'd12);
      4'd2, 4'd4, 4'd5, 4'd7, 4'd8: return TIMERW'(32'd24);
      4'd3:                         return TIMERW'(32'd48);
      4'd6, 4'd9:                   return TIMERW'(32'd2);
      default:                      return TIMERW'(32'd0);
    endcase
  endfunction

  // Active lanes are the low min(N, MAXLANES) bits; the loop bound gives the min.
  always_comb begin
    lane_mask_c = '0;
    for (int unsigned i = 0; i < MAXLANES; i++) begin
      lane_mask_c[i] = (i < 32'(numberOfDetectedLanes));
    end
  end

  assign abort_c    = !forced_q && (substate != latched_q);
  assign retry_ok_c = (32'(retry_q) + 32'd1) <= MAXRETRY;

  always_comb begin
    case (latched_q)
      SUB_DETECT_QUIET:  success_c = rxElectricalIdle || timeOut;
      SUB_DETECT_ACTIVE: success_c = 1'b1;
      default:           success_c = (lane_mask_c != '0) &&
                                     ((countersComparators & lane_mask_c) == lane_mask_c);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    latched_d   = latched_q;
    forced_d    = forced_q;
    finish_d    = 1'b0;
    exit_d      = exit_q;
    os_d        = os_q;
    dis_d       = dis_q;
    tmr_d       = tmr_q;
    en_d        = en_q;
    rt_d        = rt_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    done_exit_c = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (substate != last_q) begin
          state_d   = S_LOAD;
          latched_d = substate;
          retry_d   = 2'd0;
        end
      end
      S_LOAD: begin
        if (abort_c) begin
          state_d = S_IDLE;
        end else if (latched_q >= SUB_FIRST_INVALID) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (abort_c) begin
          state_d = S_IDLE;
        end else if (success_c) begin
          state_d     = S_DONE;
          done_exit_c = forced_q ? 4'd1 : latched_q + 4'd1;
        end else if (timeOut) begin
          if (retry_ok_c) begin
            state_d = S_LOAD;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (forceDetect) begin
      state_d   = S_LOAD;
      latched_d = SUB_DETECT_QUIET;
      forced_d  = 1'b1;
      retry_d   = 2'd0;
    end

    // Output registers take the values that belong to the state being entered.
    case (state_d)
      S_LOAD: begin
        tmr_d = timer_load(latched_d);
        cnt_d = os_count(latched_d);
        en_d  = 1'b0;
        rt_d  = 1'b0;
        os_d  = '0;
        dis_d = !((latched_d == SUB_CFG_LINKWIDTH) || (latched_d == SUB_CFG_IDLE));
      end
      S_COUNT: begin
        en_d = 1'b1;
        rt_d = 1'b1;
        os_d = lane_mask_c;
      end
      S_DONE: begin
        finish_d = 1'b1;
        exit_d   = done_exit_c;
        en_d     = 1'b0;
        rt_d     = 1'b0;
        os_d     = '0;
        last_d   = latched_q;
        forced_d = 1'b0;
      end
      default: begin
        en_d = 1'b0;
        rt_d = 1'b0;
        os_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= LAST_STATE_RST;
      latched_q <= 4'd0;
      forced_q  <= 1'b0;
      finish_q  <= 1'b0;
      exit_q    <= 4'd0;
      os_q      <= '0;
      dis_q     <= 1'b1;
      tmr_q     <= '0;
      en_q      <= 1'b0;
      rt_q      <= 1'b0;
      cnt_q     <= 5'd0;
      retry_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      latched_q <= latched_d;
      forced_q  <= forced_d;
      finish_q  <= finish_d;
      exit_q    <= exit_d;
      os_q      <= os_d;
      dis_q     <= dis_d;
      tmr_q     <= tmr_d;
      en_q      <= en_d;
      rt_q      <= rt_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
    end
  end

  assign finish             = finish_q;
  assign exitTo             = exit_q;
  assign resetOsCheckers    = os_q;
  assign disableDescrambler = dis_q;
  assign setTimer           = tmr_q;
  assign enableTimer        = en_q;
  assign resetTimer         = rt_q;
  assign comparatorsCount   = cnt_q;
  assign retryCount         = retry_q;

endmodule

// File: tb/tb_rx_ltssm_substate_controller.sv
// Bench for rx_ltssm_substate_controller: directed scenarios plus random traffic,
// every cycle compared against a request-level reference model.
module tb_rx_ltssm_substate_controller;

  localparam int unsigned LANES  = 16;
  localparam int unsigned TW     = 6;
  localparam int unsigned RETRYS = 1;

  logic             clk;
  logic             reset;
  logic [3:0]       substate;
  logic [4:0]       nlanes;
  logic [LANES-1:0] cc;
  logic             force_det;
  logic             rxei;
  logic             tmo;
  logic             finish;
  logic [3:0]       exitTo;
  logic [LANES-1:0] resetOsCheckers;
  logic             disableDescrambler;
  logic [TW-1:0]    setTimer;
  logic             enableTimer;
  logic             resetTimer;
  logic [4:0]       comparatorsCount;
  logic [1:0]       retryCount;

  rx_ltssm_substate_controller #(
    .MAXLANES(LANES), .TIMERW(TW), .MAXRETRY(RETRYS)
  ) dut (
    .clk(clk), .reset(reset), .substate(substate),
    .numberOfDetectedLanes(nlanes), .countersComparators(cc),
    .forceDetect(force_det), .rxElectricalIdle(rxei), .timeOut(tmo),
    .finish(finish), .exitTo(exitTo), .resetOsCheckers(resetOsCheckers),
    .disableDescrambler(disableDescrambler), .setTimer(setTimer),
    .enableTimer(enableTimer), .resetTimer(resetTimer),
    .comparatorsCount(comparatorsCount), .retryCount(retryCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding request moving through arming/counting/reporting
  int   cnt_tab [16] = '{0, 0, 8, 8, 2, 2, 2, 2, 8, 8, 0, 0, 0, 0, 0, 0};
  int   tmr_tab [16] = '{12, 0, 24, 48, 24, 24, 2, 24, 24, 2, 0, 0, 0, 0, 0, 0};
  logic [3:0] m_last, m_req;
  bit   m_forced, m_arming, m_counting, m_reporting;
  int   e_finish, e_exit, e_os, e_dis, e_tmr, e_en, e_rt, e_cnt, e_retry;

  function automatic int lane_mask(input int n);
    if (n >= int'(LANES)) return (1 << LANES) - 1;
    return (1 << n) - 1;
  endfunction

  task automatic go_arm();
    m_arming = 1; m_counting = 0; m_reporting = 0;
    e_tmr = tmr_tab[m_req];
    e_cnt = cnt_tab[m_req];
    e_en = 0; e_rt = 0; e_os = 0;
    e_dis = (m_req == 4'd8 || m_req == 4'd9) ? 0 : 1;
  endtask

  task automatic go_idle();
    m_arming = 0; m_counting = 0; m_reporting = 0;
    e_en = 0; e_rt = 0; e_os = 0;
  endtask

  task automatic go_report(input int nxt);
    m_arming = 0; m_counting = 0; m_reporting = 1;
    e_finish = 1; e_exit = nxt;
    e_en = 0; e_rt = 0; e_os = 0;
    m_last = m_req; m_forced = 0;
  endtask

  task automatic model_step();
    int  mk;
    bit  succ;
    mk = lane_mask(int'(nlanes));
    e_finish = 0;
    if (reset) begin
      m_last = 4'hF; m_req = 4'd0; m_forced = 0;
      m_arming = 0; m_counting = 0; m_reporting = 0;
      e_exit = 0; e_os = 0; e_dis = 1; e_tmr = 0; e_en = 0; e_rt = 0; e_cnt = 0; e_retry = 0;
    end else if (force_det) begin
      m_req = 4'd0; m_forced = 1; e_retry = 0;
      go_arm();
    end else if ((m_arming || m_counting) && !m_forced && substate != m_req) begin
      go_idle();
    end else if (m_arming) begin
      if (m_req >= 4'd10) go_report(0);
      else begin
        m_arming = 0; m_counting = 1;
        e_en = 1; e_rt = 1; e_os = mk;
      end
    end else if (m_counting) begin
      if (m_req == 4'd0)      succ = rxei || tmo;
      else if (m_req == 4'd1) succ = 1;
      else                    succ = (mk != 0) && ((int'(cc) & mk) == mk);
      if (succ) go_report(m_forced ? 1 : int'(m_req) + 1);
      else if (tmo) begin
        if (e_retry < int'(RETRYS)) begin
          e_retry++;
          go_arm();
        end else go_report(0);
      end else e_os = mk;
    end else if (m_reporting) begin
      go_idle();
    end else if (substate != m_last) begin
      m_req = substate; e_retry = 0;
      go_arm();
    end
  endtask

  always @(posedge clk) model_step();

  task automatic tick();
    @(negedge clk);
    check("finish",     32'(finish),             32'(e_finish));
    check("exitTo",     32'(exitTo),             32'(e_exit));
    check("osCheckers", 32'(resetOsCheckers),    32'(e_os));
    check("disDescr",   32'(disableDescrambler), 32'(e_dis));
    check("setTimer",   32'(setTimer),           32'(e_tmr));
    check("enTimer",    32'(enableTimer),        32'(e_en));
    check("rstTimer",   32'(resetTimer),         32'(e_rt));
    check("cmpCount",   32'(comparatorsCount),   32'(e_cnt));
    check("retry",      32'(retryCount),         32'(e_retry));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_finish(input int budget, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = finish;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    reset = 1; substate = 4'd0; nlanes = 5'd4; cc = '0;
    force_det = 0; rxei = 0; tmo = 0;
    ticks(2);
    check("rst_dis", 32'(disableDescrambler), 32'd1);
    check("rst_os",  32'(resetOsCheckers),    32'd0);

    // detectQuiet completes on electrical idle at t+3
    reset = 0; substate = 4'd0; rxei = 1;
    ticks(3);
    check("dq_finish", 32'(finish), 32'd1);
    check("dq_exit",   32'(exitTo), 32'd1);
    rxei = 0; tick();

    // detectActive completes on its first counting cycle
    substate = 4'd1;
    ticks(3);
    check("da_finish", 32'(finish), 32'd1);
    check("da_exit",   32'(exitTo), 32'd2);
    tick();

    // holding the same substate raises no new request
    ticks(4);
    check("hold_en",  32'(enableTimer), 32'd0);
    check("hold_fin", 32'(finish),      32'd0);

    // pollingActive, 4 lanes complete on the 3rd counting cycle
    substate = 4'd2; nlanes = 5'd4; cc = '0;
    tick();
    check("pa_tmr", 32'(setTimer),         32'd24);
    check("pa_cnt", 32'(comparatorsCount), 32'd8);
    tick();
    check("pa_os",  32'(resetOsCheckers), 32'h000F);
    ticks(2);
    cc = 16'h000F;
    tick();
    check("pa_finish", 32'(finish),             32'd1);
    check("pa_exit",   32'(exitTo),             32'd3);
    check("pa_dis",    32'(disableDescrambler), 32'd1);
    cc = '0; tick();

    // one timeout retry then failure
    substate = 4'd4; nlanes = 5'd3; cc = 16'h0003;
    ticks(2);
    tmo = 1; tick();
    check("rt_retry", 32'(retryCount), 32'd1);
    check("rt_rstT",  32'(resetTimer), 32'd0);
    tmo = 0; tick();
    tmo = 1; tick();
    check("rt_finish", 32'(finish), 32'd1);
    check("rt_exit",   32'(exitTo), 32'd0);
    tmo = 0; cc = '0; tick();

    // forceDetect aborts pollingConfiguration and runs detectQuiet
    substate = 4'd3; nlanes = 5'd4;
    ticks(3);
    force_det = 1; tick();
    check("fd_tmr", 32'(setTimer), 32'd12);
    check("fd_fin", 32'(finish),   32'd0);
    force_det = 0; ticks(3);
    tmo = 1; tick();
    check("fd_finish", 32'(finish), 32'd1);
    check("fd_exit",   32'(exitTo), 32'd1);
    tmo = 0; substate = 4'd0; ticks(2);

    // substate change mid-count aborts and relaunches
    substate = 4'd2; ticks(3);
    substate = 4'd8; tick();
    check("ab_fin", 32'(finish),      32'd0);
    check("ab_en",  32'(enableTimer), 32'd0);
    tick();
    check("ab_tmr", 32'(setTimer),           32'd24);
    check("ab_dis", 32'(disableDescrambler), 32'd0);
    tick();

    // out-of-range substate finishes straight to detectQuiet
    substate = 4'd12;
    wait_finish(8, "inv_wait");
    check("inv_exit", 32'(exitTo), 32'd0);
    tick();

    // reset mid-count, then relaunch of the held request
    substate = 4'd5; nlanes = 5'd4; cc = '0;
    ticks(2);
    reset = 1; tick();
    check("rs_fin", 32'(finish),             32'd0);
    check("rs_os",  32'(resetOsCheckers),    32'd0);
    check("rs_dis", 32'(disableDescrambler), 32'd1);
    check("rs_tmr", 32'(setTimer),           32'd0);
    check("rs_en",  32'(enableTimer),        32'd0);
    reset = 0; tick();
    check("rl_tmr", 32'(setTimer),         32'd24);
    check("rl_cnt", 32'(comparatorsCount), 32'd2);
    tick();
    cc = 16'hFFFF; tick();
    check("rl_finish", 32'(finish), 32'd1);
    check("rl_exit",   32'(exitTo), 32'd6);
    cc = '0; tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) substate = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) nlanes = 5'($urandom_range(0, 20));
      cc        = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      tmo       = ($urandom_range(0, 11) == 0);
      rxei      = ($urandom_range(0, 9) == 0);
      force_det = ($urandom_range(0, 79) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
